sync_reset_sequencer: RTL and testbench
=======================================

# sync_reset_sequencer

Multi-output reset sequencer: takes one asynchronous active-high reset and produces NOUT active-high reset outputs. Every output asserts asynchronously and together. Outputs deassert one at a time, in index order, after synchronisation, a minimum hold period and a fixed gap between stages. A synchronous software reset request re-runs the whole sequence. The block sits at each clock-domain root, between the board/PLL reset and the domain's subsystems that need ordered bring-up.

## Interface
- NOUT, 4: number of reset outputs, ≥1.
- RSTDELAY, 1: extra synchroniser stages for IN_RST deassertion; chain length is RSTDELAY+1, RSTDELAY ≥ 0.
- MIN_HOLD, 16: cycles all outputs stay asserted after the synchronised release or an SW_RST, 1..65535.
- STAGE_GAP, 8: cycles between successive output releases, 1..65535.
- CLK  input  1  clock; all state on posedge.
- IN_RST  input  1  reset, asynchronous, active-high; asserts all state immediately.
- SW_RST  input  1  synchronous software reset request, active-high level.
- OUT_RST  output  NOUT  per-stage reset, active-high, registered.
- ALL_RELEASED  output  1  high once OUT_RST is all zero, registered.
- RST_COUNT  output  8  saturating count of SW_RST rising edges since IN_RST.

## Operation
- Synchroniser: sync[RSTDELAY:0] is async-set to all ones by IN_RST. Each edge shifts in 0. rst_sync = sync[RSTDELAY].
- State: HOLD, RELEASE, DONE. Hold/gap counter is 16 bits. Stage index is clog2(NOUT) bits, minimum 1. OUT_RST = ~rel, where rel[NOUT-1:0] is the release mask.
- IN_RST high, asynchronous, with priority over everything:
  - sync = all ones; state = HOLD; counter = 0; rel = 0.
  - OUT_RST = all ones; ALL_RELEASED = 0; RST_COUNT = 0; sw_prev = 1.
- While rst_sync = 1: state held in HOLD, counter held at 0, SW_RST ignored.
- HOLD, rst_sync = 0:
  - If counter == MIN_HOLD-1: set rel[0]; counter = 0; idx = 0.
    - If NOUT == 1: go to DONE and set ALL_RELEASED on the same edge.
    - Otherwise go to RELEASE.
  - Else: counter += 1.
- RELEASE:
  - If counter == STAGE_GAP-1: set rel[idx+1]; idx += 1; counter = 0.
    - If idx+1 == NOUT-1: go to DONE and set ALL_RELEASED on the same edge.
  - Else: counter += 1.
- DONE: hold all state.
- SW_RST sampled high at an edge with rst_sync = 0, in any state:
  - rel = 0; ALL_RELEASED = 0; state = HOLD; counter = 0.
  - This overrides every transition in the same edge.
  - While SW_RST stays high, the block re-enters HOLD with counter 0 every edge, so the sequence starts only after SW_RST drops.
- RST_COUNT:
  - sw_prev <= SW_RST every edge.
  - Increment when SW_RST & ~sw_prev & ~rst_sync.
  - Saturates at 255.
- Released outputs never reassert except on IN_RST or SW_RST.

## Timing
- Edge numbering: edge 1 is the first posedge after IN_RST falls.
- rst_sync falls after edge E = RSTDELAY+1.
- OUT_RST[i] falls after edge E + MIN_HOLD + i·STAGE_GAP.
- ALL_RELEASED rises on the same edge as OUT_RST[NOUT-1] falls.
- SW_RST: if SW_RST is high at edge k and low from edge k+1:
  - All OUT_RST are high after edge k.
  - OUT_RST[i] falls after edge k + MIN_HOLD + i·STAGE_GAP.
- Assertion latency:
  - IN_RST: combinational through the async set/clear, 0 cycles.
  - SW_RST: 1 edge.
- IN_RST deasserting near a CLK edge: the synchroniser absorbs the metastability. Only the release edge may shift, by ±1 cycle.
- IN_RST pulse mid-sequence, at any state or idx: immediate full reassertion, then the full sequence restarts from edge 1.

## Test plan
- Defaults; IN_RST high 5 cycles, then low -> OUT_RST stays 4'b1111 through edge 17. Then 4'b1110 after edge 18, 4'b1100 after 26, 4'b1000 after 34, 4'b0000 after 42. ALL_RELEASED = 1 after 42; RST_COUNT = 0.
- Defaults, DONE reached; SW_RST high for one cycle at edge 100 -> OUT_RST = 4'b1111 and ALL_RELEASED = 0 after 100. Bits release after edges 116/124/132/140; RST_COUNT = 1.
- SW_RST held high edges 100–109 -> count increments once only. OUT_RST[0] falls after edge 109+16 = 125.
- IN_RST asserted mid-RELEASE, after OUT_RST = 4'b1100, between edges -> OUT_RST = 4'b1111 immediately without a clock edge; RST_COUNT = 0. Sequence restarts per the first scenario.
- NOUT = 1, RSTDELAY = 0, MIN_HOLD = 1, STAGE_GAP = 1 -> OUT_RST falls after edge 2 and ALL_RELEASED rises after edge 2. Also: SW_RST high while rst_sync = 1 is ignored and not counted.
- 300 SW_RST pulses, each 1 cycle high then 2 low -> RST_COUNT saturates at 255 and never wraps.

Source files
------------

// File: rtl/sync_reset_sequencer.sv
// Reset sequencer for a clock-domain root: asserts all NOUT reset outputs at once,
// then releases them one by one in index order after a hold period and fixed gaps.
module sync_reset_sequencer #(
   parameter int NOUT      = 4,
   parameter int RSTDELAY  = 1,
   parameter int MIN_HOLD  = 16,
   parameter int STAGE_GAP = 8
) (
   input  logic            CLK,
   input  logic            IN_RST,
   input  logic            SW_RST,
   output logic [NOUT-1:0] OUT_RST,
   output logic            ALL_RELEASED,
   output logic [7:0]      RST_COUNT
);

   localparam int              IDXW      = (NOUT > 1) ? $clog2(NOUT) : 1;
   localparam logic [15:0]     HOLD_LAST = 16'(MIN_HOLD - 1);
   localparam logic [15:0]     GAP_LAST  = 16'(STAGE_GAP - 1);
   localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(NOUT - 1);
   localparam logic [NOUT-1:0] ONE_HOT0  = NOUT'(1);

   typedef enum logic [1:0] {
      ST_HOLD,
      ST_RELEASE,
      ST_DONE
   } state_t;

   state_t            state;
   logic [15:0]       count;
   logic [IDXW-1:0]   idx;
   logic [IDXW-1:0]   idx_next;
   logic [RSTDELAY:0] sync;
   logic              rst_sync;
   logic              sw_prev;

   assign rst_sync = sync[RSTDELAY];
   assign idx_next = idx + 1'b1;

   // Release path of IN_RST is synchronised; assertion stays asynchronous.
   always_ff @(posedge CLK or posedge IN_RST) begin
      if (IN_RST) begin
         sync <= '1;
      end else begin
         sync <= sync << 1;
      end
   end

   always_ff @(posedge CLK or posedge IN_RST) begin
      if (IN_RST) begin
         state        <= ST_HOLD;
         count        <= '0;
         idx          <= '0;
         OUT_RST      <= '1;
         ALL_RELEASED <= 1'b0;
      end else if (rst_sync) begin
         state <= ST_HOLD;
         count <= '0;
      end else if (SW_RST) begin
         // A software request restarts the hold; it wins over any release this edge.
         state        <= ST_HOLD;
         count        <= '0;
         idx          <= '0;
         OUT_RST      <= '1;
         ALL_RELEASED <= 1'b0;
      end else begin
         case (state)
            ST_HOLD: begin
               if (count == HOLD_LAST) begin
                  OUT_RST[0] <= 1'b0;
                  count      <= '0;
                  idx        <= '0;
                  if (NOUT == 1) begin
                     state        <= ST_DONE;
                     ALL_RELEASED <= 1'b1;
                  end else begin
                     state <= ST_RELEASE;
                  end
               end else begin
                  count <= count + 16'd1;
               end
            end
            ST_RELEASE: begin
               if (count == GAP_LAST) begin
                  OUT_RST <= OUT_RST & ~(ONE_HOT0 << idx_next);
                  idx     <= idx_next;
                  count   <= '0;
                  if (idx_next == IDX_LAST) begin
                     state        <= ST_DONE;
                     ALL_RELEASED <= 1'b1;
                  end
               end else begin
                  count <= count + 16'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Counts software reset requests only once the block is out of the synchroniser window.
   always_ff @(posedge CLK or posedge IN_RST) begin
      if (IN_RST) begin
         sw_prev   <= 1'b1;
         RST_COUNT <= '0;
      end else begin
         sw_prev <= SW_RST;
         if (SW_RST && !sw_prev && !rst_sync && (RST_COUNT != 8'hFF)) begin
            RST_COUNT <= RST_COUNT + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_sync_reset_sequencer.sv
// Bench for sync_reset_sequencer: directed scenarios plus random SW/IN_RST traffic
// compared every cycle against a release-time model.
module tb_sync_reset_sequencer;

   localparam int NOUT      = 4;
   localparam int RSTDELAY  = 1;
   localparam int MIN_HOLD  = 16;
   localparam int STAGE_GAP = 8;
   localparam int E         = RSTDELAY + 1;

   logic            clk = 1'b0;
   logic            in_rst = 1'b1;
   logic            sw_rst = 1'b0;
   logic [NOUT-1:0] out_rst;
   logic            all_released;
   logic [7:0]      rst_count;

   logic            in_rst_b = 1'b1;
   logic            sw_rst_b = 1'b0;
   logic [0:0]      out_rst_b;
   logic            all_released_b;
   logic [7:0]      rst_count_b;

   int testCount = 0;
   int failCount = 0;
   bit monitorOn = 1'b0;

   int edgeNum     = 0;
   int anchor      = E;
   int modelCount  = 0;
   bit modelSwPrev = 1'b1;

   always #5 clk = ~clk;

   sync_reset_sequencer #(
      .NOUT(NOUT), .RSTDELAY(RSTDELAY), .MIN_HOLD(MIN_HOLD), .STAGE_GAP(STAGE_GAP)
   ) dut (
      .CLK(clk), .IN_RST(in_rst), .SW_RST(sw_rst),
      .OUT_RST(out_rst), .ALL_RELEASED(all_released), .RST_COUNT(rst_count)
   );

   sync_reset_sequencer #(
      .NOUT(1), .RSTDELAY(0), .MIN_HOLD(1), .STAGE_GAP(1)
   ) dut_b (
      .CLK(clk), .IN_RST(in_rst_b), .SW_RST(sw_rst_b),
      .OUT_RST(out_rst_b), .ALL_RELEASED(all_released_b), .RST_COUNT(rst_count_b)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Model: output i drops once the edge count reaches anchor + MIN_HOLD + i*STAGE_GAP,
   // where anchor is the synchroniser release edge or the last SW_RST-high edge.
   always @(posedge clk or posedge in_rst) begin
      if (in_rst) begin
         edgeNum     <= 0;
         anchor      <= E;
         modelSwPrev <= 1'b1;
         modelCount  <= 0;
      end else begin
         edgeNum     <= edgeNum + 1;
         modelSwPrev <= sw_rst;
         if (sw_rst && (edgeNum + 1 > E)) begin
            anchor <= edgeNum + 1;
            if (!modelSwPrev && modelCount < 255) modelCount <= modelCount + 1;
         end
      end
   end

   function automatic logic [NOUT-1:0] modelOut(input int n, input int a);
      logic [NOUT-1:0] r;
      r = '0;
      for (int i = 0; i < NOUT; i++) r[i] = (n < a + MIN_HOLD + i * STAGE_GAP);
      return r;
   endfunction

   always @(negedge clk) begin
      if (monitorOn) begin
         logic [NOUT-1:0] e;
         e = modelOut(edgeNum, anchor);
         checkOutput("mon_out_rst", 32'(out_rst), 32'(e));
         checkOutput("mon_all_released", 32'(all_released), 32'(e == '0));
         checkOutput("mon_rst_count", 32'(rst_count), 32'(modelCount));
      end
   end

   // Drives the main DUT inputs, then waits the given number of edges (ends at negedge+1).
   task automatic applyStimulus(input bit rstVal, input bit swVal, input int cycles);
      in_rst = rstVal;
      sw_rst = swVal;
      repeat (cycles) @(negedge clk);
      #1;
   endtask

   initial begin
      // Small configuration: NOUT=1, no extra sync stage, minimal hold and gap.
      repeat (3) @(negedge clk);
      #1;
      in_rst_b = 1'b0;
      sw_rst_b = 1'b1;
      @(negedge clk); #1;
      checkOutput("b_e1_out", 32'(out_rst_b), 32'd1);
      checkOutput("b_e1_released", 32'(all_released_b), 32'd0);
      sw_rst_b = 1'b0;
      @(negedge clk); #1;
      checkOutput("b_e2_out", 32'(out_rst_b), 32'd0);
      checkOutput("b_e2_released", 32'(all_released_b), 32'd1);
      checkOutput("b_e2_count", 32'(rst_count_b), 32'd0);
      sw_rst_b = 1'b1;
      @(negedge clk); #1;
      checkOutput("b_sw_out", 32'(out_rst_b), 32'd1);
      checkOutput("b_sw_count", 32'(rst_count_b), 32'd1);
      sw_rst_b = 1'b0;
      @(negedge clk); #1;
      checkOutput("b_sw_rel_out", 32'(out_rst_b), 32'd0);
      checkOutput("b_sw_rel_released", 32'(all_released_b), 32'd1);

      // Power-on sequence with defaults.
      monitorOn = 1'b1;
      applyStimulus(1'b1, 1'b0, 2);
      applyStimulus(1'b0, 1'b0, 17);
      checkOutput("s1_e17", 32'(out_rst), 32'hF);
      applyStimulus(1'b0, 1'b0, 1);
      checkOutput("s1_e18", 32'(out_rst), 32'hE);
      applyStimulus(1'b0, 1'b0, 8);
      checkOutput("s1_e26", 32'(out_rst), 32'hC);
      applyStimulus(1'b0, 1'b0, 8);
      checkOutput("s1_e34", 32'(out_rst), 32'h8);
      applyStimulus(1'b0, 1'b0, 8);
      checkOutput("s1_e42", 32'(out_rst), 32'h0);
      checkOutput("s1_e42_released", 32'(all_released), 32'd1);
      checkOutput("s1_e42_count", 32'(rst_count), 32'd0);
      applyStimulus(1'b0, 1'b0, 57);

      // Single-cycle SW_RST at edge 100.
      applyStimulus(1'b0, 1'b1, 1);
      checkOutput("s2_e100", 32'(out_rst), 32'hF);
      checkOutput("s2_e100_released", 32'(all_released), 32'd0);
      applyStimulus(1'b0, 1'b0, 15);
      checkOutput("s2_e115", 32'(out_rst), 32'hF);
      applyStimulus(1'b0, 1'b0, 1);
      checkOutput("s2_e116", 32'(out_rst), 32'hE);
      applyStimulus(1'b0, 1'b0, 24);
      checkOutput("s2_e140", 32'(out_rst), 32'h0);
      checkOutput("s2_count", 32'(rst_count), 32'd1);

      // SW_RST held for 10 edges (141..150) counts once; bit 0 drops 16 edges later.
      applyStimulus(1'b0, 1'b1, 10);
      applyStimulus(1'b0, 1'b0, 15);
      checkOutput("s3_hold_out", 32'(out_rst), 32'hF);
      applyStimulus(1'b0, 1'b0, 1);
      checkOutput("s3_first_rel", 32'(out_rst), 32'hE);
      checkOutput("s3_count", 32'(rst_count), 32'd2);
      applyStimulus(1'b0, 1'b0, 8);
      checkOutput("s3_mid_release", 32'(out_rst), 32'hC);

      // IN_RST mid-release, between edges.
      #2;
      in_rst = 1'b1;
      #1;
      checkOutput("s4_async_out", 32'(out_rst), 32'hF);
      checkOutput("s4_async_count", 32'(rst_count), 32'd0);
      checkOutput("s4_async_released", 32'(all_released), 32'd0);
      repeat (3) @(negedge clk);
      #1;
      applyStimulus(1'b0, 1'b0, 17);
      checkOutput("s4_e17", 32'(out_rst), 32'hF);
      applyStimulus(1'b0, 1'b0, 1);
      checkOutput("s4_e18", 32'(out_rst), 32'hE);
      applyStimulus(1'b0, 1'b0, 30);

      // Random SW_RST pulses, idle stretches and asynchronous IN_RST pulses.
      for (int it = 0; it < 300; it++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 5) begin
            applyStimulus(1'b0, 1'b0, $urandom_range(1, 25));
         end else if (r < 9) begin
            applyStimulus(1'b0, 1'b1, $urandom_range(1, 4));
            applyStimulus(1'b0, 1'b0, 1);
         end else begin
            #($urandom_range(0, 3));
            in_rst = 1'b1;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            #($urandom_range(1, 3));
            in_rst = 1'b0;
            @(negedge clk);
            #1;
         end
      end

      // Saturation: 300 one-cycle pulses from a fresh reset.
      applyStimulus(1'b1, 1'b0, 2);
      applyStimulus(1'b0, 1'b0, 5);
      for (int p = 0; p < 300; p++) begin
         applyStimulus(1'b0, 1'b1, 1);
         applyStimulus(1'b0, 1'b0, 2);
      end
      checkOutput("sat_count", 32'(rst_count), 32'd255);
      applyStimulus(1'b0, 1'b0, 50);
      checkOutput("sat_final_out", 32'(out_rst), 32'h0);

      monitorOn = 1'b0;
      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
